// File: rtl/bit_serial_subtractor_if.sv
// Handshake and operand/result bundle for bit_serial_subtractor.
// master drives the request, slave returns status and result.
interface bit_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Serial a - b - bin, one bit per clock, LSB first, via one full_subtractor.
// Optional macro BIT_SERIAL_SUB_OVF_EN enables the signed overflow flag.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  bit_serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_brw;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = bus.start && !w_run;
  assign w_last   = w_run && (r_cnt == CW'(WIDTH - 1));

  full_subtractor u_fs (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_bin  (r_brw),
    .o_d    (w_d),
    .o_bout (w_bo)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_brw  <= 1'b0;
      r_bout <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sr <= bus.a;
      r_b_sr <= bus.b;
      r_brw  <= bus.bin;
      r_cnt  <= '0;
    end else if (w_run) begin
      r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_res  <= {w_d, r_res[WIDTH-1:1]};
      r_brw  <= w_bo;
      r_cnt  <= r_cnt + 1'b1;
      // Publish only the completed word so diff never shows partials
      if (w_last) begin
        r_diff <= {w_d, r_res[WIDTH-1:1]};
        r_bout <= w_bo;
      end
    end
  end

`ifdef BIT_SERIAL_SUB_OVF_EN
  logic r_bmsb;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_bmsb <= 1'b0;
    else if (w_last) r_bmsb <= r_brw;
  end

  assign bus.ovf = r_bmsb ^ r_bout;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Bench for bit_serial_subtractor at WIDTH=8 and WIDTH=5.
// Directed table, multi-cycle corner sequences and random vs. an arithmetic model.
module tb_bit_serial_subtractor;
`ifdef BIT_SERIAL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  bit_serial_subtractor_if #(.WIDTH(8)) b8 ();
  bit_serial_subtractor_if #(.WIDTH(5)) b5 ();

  bit_serial_subtractor #(.WIDTH(8)) u8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b8.slave)
  );

  bit_serial_subtractor #(.WIDTH(5)) u5 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    bit bin;
    int d;
    bit bo;
    bit ov;
  } vec_t;

  typedef struct {
    int d;
    bit bo;
    bit ov;
  } res_t;

  function automatic res_t model(int w, int a, int b, bit bin);
    res_t r;
    int m;
    int u;
    int sa;
    int sb;
    int s;
    m = 1 << w;
    u = a - b - int'(bin);
    r.d = ((u % m) + m) % m;
    r.bo = (u < 0);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    s = sa - sb - int'(bin);
    r.ov = OVF_EN && ((s < -(m / 2)) || (s >= m / 2));
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(int w, bit st, int a, int b, bit bn);
    if (w == 8) begin
      b8.start = st;
      b8.a = 8'(a);
      b8.b = 8'(b);
      b8.bin = bn;
    end else begin
      b5.start = st;
      b5.a = 5'(a);
      b5.b = 5'(b);
      b5.bin = bn;
    end
  endtask

  function automatic bit f_done(int w);
    return (w == 8) ? b8.done : b5.done;
  endfunction

  function automatic bit f_busy(int w);
    return (w == 8) ? b8.busy : b5.busy;
  endfunction

  function automatic int f_diff(int w);
    return (w == 8) ? int'(b8.diff) : int'(b5.diff);
  endfunction

  function automatic bit f_bout(int w);
    return (w == 8) ? b8.bout : b5.bout;
  endfunction

  function automatic bit f_ovf(int w);
    return (w == 8) ? b8.ovf : b5.ovf;
  endfunction

  // n = edges elapsed since the reference edge at the current negedge
  task automatic wait_done(int w, int n0, output int n, output int bc);
    n = n0;
    bc = 0;
    while (!f_done(w) && n < 40) begin
      if (f_busy(w)) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic accept(int w, int a, int b, bit bn);
    @(negedge clk);
    drv(w, 1'b1, a, b, bn);
    @(negedge clk);
    drv(w, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic chk_res(string nm, int w, res_t e);
    chk({nm, ".diff"}, f_diff(w), e.d);
    chk({nm, ".bout"}, int'(f_bout(w)), int'(e.bo));
    chk({nm, ".ovf"}, int'(f_ovf(w)), int'(e.ov));
  endtask

  vec_t tbl[5];
  res_t e;
  int   n;
  int   bc;
  int   pulses;
  int   ra;
  int   rb;
  bit   rbn;

  initial begin
    errs = 0;
    checks = 0;
    rst = 1'b1;
    drv(8, 1'b0, 0, 0, 1'b0);
    drv(5, 1'b0, 0, 0, 1'b0);

    tbl[0] = '{a: 'h5A, b: 'h3C, bin: 0, d: 'h1E, bo: 0, ov: 0};
    tbl[1] = '{a: 'h00, b: 'h01, bin: 0, d: 'hFF, bo: 1, ov: 0};
    tbl[2] = '{a: 'h10, b: 'h10, bin: 1, d: 'hFF, bo: 1, ov: 0};
    tbl[3] = '{a: 'h80, b: 'h01, bin: 0, d: 'h7F, bo: 0, ov: OVF_EN};
    tbl[4] = '{a: 'h7F, b: 'hFF, bin: 0, d: 'h80, bo: 1, ov: OVF_EN};

    repeat (2) @(negedge clk);
    chk("rst.busy", int'(b8.busy), 0);
    chk("rst.done", int'(b8.done), 0);
    chk("rst.diff", int'(b8.diff), 0);
    chk("rst.bout", int'(b8.bout), 0);
    chk("rst.ovf", int'(b8.ovf), 0);
    chk("rst.busy5", int'(b5.busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      accept(8, tbl[i].a, tbl[i].b, tbl[i].bin);
      wait_done(8, 0, n, bc);
      chk($sformatf("tbl%0d.lat", i), n, 8);
      chk($sformatf("tbl%0d.busy", i), bc, 8);
      chk($sformatf("tbl%0d.diff", i), int'(b8.diff), tbl[i].d);
      chk($sformatf("tbl%0d.bout", i), int'(b8.bout), int'(tbl[i].bo));
      chk($sformatf("tbl%0d.ovf", i), int'(b8.ovf), int'(tbl[i].ov));
      @(negedge clk);
      chk($sformatf("tbl%0d.pulse", i), int'(b8.done), 0);
    end

    // start pulse mid-RUN is ignored, then start held in DONE
    accept(8, 'h5A, 'h3C, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drv(8, 1'b1, 'hFF, 'h00, 1'b1);
    @(negedge clk);
    drv(8, 1'b0, 0, 0, 1'b0);
    wait_done(8, 3, n, bc);
    chk("ign.lat", n, 8);
    chk("ign.diff", int'(b8.diff), 'h1E);
    drv(8, 1'b1, 'h03, 'h01, 1'b0);
    @(negedge clk);
    drv(8, 1'b0, 0, 0, 1'b0);
    chk("b2b.busy", int'(b8.busy), 1);
    wait_done(8, 1, n, bc);
    chk("b2b.lat", n, 9);
    chk("b2b.diff", int'(b8.diff), 'h02);
    chk("b2b.bout", int'(b8.bout), 0);

    // reset mid-RUN aborts with no done pulse
    accept(8, 'h00, 'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.busy", int'(b8.busy), 0);
    chk("mrst.done", int'(b8.done), 0);
    chk("mrst.diff", int'(b8.diff), 0);
    chk("mrst.bout", int'(b8.bout), 0);
    chk("mrst.ovf", int'(b8.ovf), 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b8.done || b8.busy) pulses++;
    end
    chk("mrst.quiet", pulses, 0);
    accept(8, 'h80, 'h01, 1'b0);
    wait_done(8, 0, n, bc);
    chk("mrst.lat", n, 8);
    e = model(8, 'h80, 'h01, 1'b0);
    chk_res("mrst.op", 8, e);

    for (int w = 5; w <= 8; w += 3) begin
      for (int i = 0; i < 1000; i++) begin
        ra = int'($urandom_range((1 << w) - 1, 0));
        rb = int'($urandom_range((1 << w) - 1, 0));
        rbn = 1'($urandom_range(1, 0));
        accept(w, ra, rb, rbn);
        wait_done(w, 0, n, bc);
        chk($sformatf("rnd%0d.lat", w), n, w);
        e = model(w, ra, rb, rbn);
        chk_res($sformatf("rnd%0d_%0h_%0h_%0d", w, ra, rb, rbn), w, e);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
